// File: rtl/tlb_refill_ctrl_pkg.sv
// Shared types and constants for the TLB refill controller and the TLB.
// Provides the FSM state encoding, PTE field positions and the PTE address helper.
package tlb_refill_ctrl_pkg;

  localparam int VPN_W = 20;
  localparam int OFF_W = 12;
  localparam int TMO_W = 8;
  localparam int WALK_TIMEOUT = 200;

  localparam int PTE_V_BIT = 0;
  localparam int PTE_D_BIT = 1;
  localparam int PTE_PPN_LSB = 12;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WALK_REQ,
    WALK_WAIT,
    REFILL,
    RESP
  } state_t;

  // Single-level table of 4-byte PTEs indexed by VPN; wraps mod 2^32.
  function automatic logic [31:0] pte_addr(
    input logic [31:0] base,
    input logic [31:0] va
  );
    return base + {{(32-VPN_W-2){1'b0}}, va[31:OFF_W], 2'b00};
  endfunction

endpackage

// File: rtl/tlb_refill_ctrl_if.sv
// Bundle of requester, TLB and PTE-memory signals around the refill controller.
// slave: controller view; master: environment view (requester, TLB, memory).
interface tlb_refill_ctrl_if;
  import tlb_refill_ctrl_pkg::*;

  logic [31:0]      ptbr;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_vaddr;
  logic             req_is_store;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_paddr;
  logic             resp_fault;
  logic [31:0]      tlb_vaddr;
  logic             tlb_hit;
  logic [31:0]      tlb_paddr;
  logic             tlb_we;
  logic [VPN_W-1:0] tlb_vpn;
  logic [VPN_W-1:0] tlb_ppn;
  logic             tlb_dirty;
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [31:0]      mem_addr;
  logic             mem_rdata_valid;
  logic [31:0]      mem_rdata;

  modport slave (
    input  ptbr, req_valid, req_vaddr, req_is_store,
    input  resp_ready, tlb_hit, tlb_paddr,
    input  mem_req_ready, mem_rdata_valid, mem_rdata,
    output req_ready, resp_valid, resp_paddr, resp_fault,
    output tlb_vaddr, tlb_we, tlb_vpn, tlb_ppn, tlb_dirty,
    output mem_req_valid, mem_addr
  );

  modport master (
    output ptbr, req_valid, req_vaddr, req_is_store,
    output resp_ready, tlb_hit, tlb_paddr,
    output mem_req_ready, mem_rdata_valid, mem_rdata,
    input  req_ready, resp_valid, resp_paddr, resp_fault,
    input  tlb_vaddr, tlb_we, tlb_vpn, tlb_ppn, tlb_dirty,
    input  mem_req_valid, mem_addr
  );

endinterface

// File: rtl/tlb_walk_timer.sv
// Walk timeout counter: clr loads zero, en counts up one per cycle.
// Ports: clk, reset, clr, en, limit; done flags the cycle whose count reaches limit.
module tlb_walk_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;

  assign cnt_nxt = W'(cnt + 1'b1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt_nxt;
    end
  end

  // Raised while the edge ending this cycle brings the count to limit.
  assign done = en && (cnt_nxt == limit);

endmodule

// File: rtl/tlb_refill_ctrl.sv
// TLB probe and single-level page-table walker for one requester.
// Ports: clk, reset (async, active high), bus (slave view of tlb_refill_ctrl_if).
module tlb_refill_ctrl
  import tlb_refill_ctrl_pkg::*;
#(
  parameter int TMO_W        = tlb_refill_ctrl_pkg::TMO_W,
  parameter int WALK_TIMEOUT = tlb_refill_ctrl_pkg::WALK_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  tlb_refill_ctrl_if.slave bus
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(WALK_TIMEOUT);

  state_t state;
  state_t state_nxt;

  logic [31:0]      vaddr_q;
  logic             store_q;
  logic [31:0]      ptbr_q;
  logic [VPN_W-1:0] ppn_q;
  logic             pte_d_q;
  logic [31:0]      paddr_q;
  logic             fault_q;

  logic tmo_clr;
  logic tmo_en;
  logic tmo_done;
  logic pte_ok;
  logic unused_pte;

  assign pte_ok     = bus.mem_rdata[PTE_V_BIT];
  assign unused_pte = ^bus.mem_rdata[PTE_PPN_LSB-1:PTE_D_BIT+1];
  assign tmo_clr    = (state == WALK_REQ) && bus.mem_req_ready;
  assign tmo_en     = (state == WALK_WAIT);

  tlb_walk_timer #(
    .W(TMO_W)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clr  (tmo_clr),
    .en   (tmo_en),
    .limit(TMO_LIMIT),
    .done (tmo_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        state_nxt = bus.tlb_hit ? RESP : WALK_REQ;
      end
      WALK_REQ: begin
        if (bus.mem_req_ready) state_nxt = WALK_WAIT;
      end
      WALK_WAIT: begin
        // Data arriving on the timeout cycle still wins.
        if (bus.mem_rdata_valid) begin
          state_nxt = pte_ok ? REFILL : RESP;
        end else if (tmo_done) begin
          state_nxt = RESP;
        end
      end
      REFILL: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vaddr_q <= '0;
      store_q <= 1'b0;
      ptbr_q  <= '0;
      ppn_q   <= '0;
      pte_d_q <= 1'b0;
      paddr_q <= '0;
      fault_q <= 1'b0;
    end else begin
      unique case (1'b1)
        state == IDLE: begin
          if (bus.req_valid) begin
            vaddr_q <= bus.req_vaddr;
            store_q <= bus.req_is_store;
            ptbr_q  <= bus.ptbr;
          end
        end
        state == LOOKUP: begin
          if (bus.tlb_hit) begin
            paddr_q <= bus.tlb_paddr;
            fault_q <= 1'b0;
          end
        end
        state == WALK_WAIT: begin
          if (bus.mem_rdata_valid) begin
            ppn_q   <= bus.mem_rdata[31:PTE_PPN_LSB];
            pte_d_q <= bus.mem_rdata[PTE_D_BIT];
            if (!pte_ok) begin
              paddr_q <= '0;
              fault_q <= 1'b1;
            end
          end else if (tmo_done) begin
            paddr_q <= '0;
            fault_q <= 1'b1;
          end
        end
        state == REFILL: begin
          paddr_q <= {ppn_q, vaddr_q[OFF_W-1:0]};
          fault_q <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    // reset gates ready because the async reset already forces IDLE.
    bus.req_ready     = (state == IDLE) && !reset;
    bus.tlb_vaddr     = vaddr_q;
    bus.mem_req_valid = 1'b0;
    bus.mem_addr      = '0;
    bus.tlb_we        = 1'b0;
    bus.tlb_vpn       = '0;
    bus.tlb_ppn       = '0;
    bus.tlb_dirty     = 1'b0;
    bus.resp_valid    = 1'b0;
    bus.resp_paddr    = '0;
    bus.resp_fault    = 1'b0;
    unique case (state)
      WALK_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_addr      = pte_addr(ptbr_q, vaddr_q);
      end
      REFILL: begin
        bus.tlb_we    = 1'b1;
        bus.tlb_vpn   = vaddr_q[31:OFF_W];
        bus.tlb_ppn   = ppn_q;
        bus.tlb_dirty = pte_d_q | store_q;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_paddr = paddr_q;
        bus.resp_fault = fault_q;
      end
      default: begin
      end
    endcase
  end

endmodule
